// File: rtl/commit_trace_buf.sv
// Commit trace FIFO: captures retiring instructions from writeback and presents them
// to a trace sink in order, with back-pressure, drop accounting and sequence numbering.
module commit_trace_buf #(
   parameter int DEPTH = 8,
   parameter int AFULL = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    commit_i,
   input  logic [63:0]             pc_i,
   input  logic [31:0]             inst_i,
   input  logic                    rf_we_i,
   input  logic [4:0]              rf_waddr_i,
   input  logic [63:0]             rf_wdata_i,
   output logic                    trc_valid_o,
   input  logic                    trc_ready_i,
   output logic [63:0]             trc_pc_o,
   output logic [31:0]             trc_inst_o,
   output logic                    trc_we_o,
   output logic [4:0]              trc_waddr_o,
   output logic [63:0]             trc_wdata_o,
   output logic [31:0]             trc_seq_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    stall_o,
   output logic                    overflow_o,
   output logic [15:0]             drop_cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL);

   logic [63:0]   pc_mem    [DEPTH];
   logic [31:0]   inst_mem  [DEPTH];
   logic          we_mem    [DEPTH];
   logic [4:0]    waddr_mem [DEPTH];
   logic [63:0]   wdata_mem [DEPTH];
   logic [31:0]   seq_mem   [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_nxt;
   logic [31:0]   seq_q;
   logic          stall_q;
   logic          overflow_q;
   logic [15:0]   drop_cnt_q;
   logic          push;
   logic          pop;
   logic          drop;
   logic          stored_we;

   // A pop in the same cycle frees the slot, so a full buffer can still accept a push.
   always_comb begin
      pop       = (count_q != '0) && trc_ready_i;
      push      = commit_i && ((count_q != DEPTH_C) || pop);
      drop      = commit_i && (count_q == DEPTH_C) && !pop;
      stored_we = rf_we_i && (rf_waddr_i != 5'd0);
      count_nxt = count_q;
      if (push && !pop) begin
         count_nxt = count_q + CW'(1);
      end else if (pop && !push) begin
         count_nxt = count_q - CW'(1);
      end
   end

   // Control state; stall is registered from next-state occupancy so it tracks count_o.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         seq_q      <= '0;
         stall_q    <= 1'b0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            seq_q  <= seq_q + 32'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count_q <= count_nxt;
         stall_q <= (count_nxt >= AFULL_C);
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
               drop_cnt_q <= drop_cnt_q + 16'd1;
            end
         end
      end
   end

   // Entry storage carries no reset; a commit during reset is never written.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         pc_mem[wr_ptr]    <= pc_i;
         inst_mem[wr_ptr]  <= inst_i;
         we_mem[wr_ptr]    <= stored_we;
         waddr_mem[wr_ptr] <= rf_waddr_i;
         wdata_mem[wr_ptr] <= stored_we ? rf_wdata_i : 64'h0;
         seq_mem[wr_ptr]   <= seq_q;
      end
   end

   assign trc_valid_o = (count_q != '0);
   assign trc_pc_o    = pc_mem[rd_ptr];
   assign trc_inst_o  = inst_mem[rd_ptr];
   assign trc_we_o    = we_mem[rd_ptr];
   assign trc_waddr_o = waddr_mem[rd_ptr];
   assign trc_wdata_o = wdata_mem[rd_ptr];
   assign trc_seq_o   = seq_mem[rd_ptr];
   assign count_o     = count_q;
   assign stall_o     = stall_q;
   assign overflow_o  = overflow_q;
   assign drop_cnt_o  = drop_cnt_q;

endmodule
